// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter.
//   tx_state_t : transmitter FSM states
//   DATA_BITS  : payload width of one frame
package serial_pkg;
  localparam int DATA_BITS = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer for the serial transmitter.
//   Clk      : system clock
//   Reset    : synchronous, active-low
//   En       : count while high; counter clears whenever low
//   Tick     : high in the last cycle of each bit period
//   TickNext : high in the cycle before Tick (every enabled cycle when a bit
//              is a single cycle long), lets the caller register outputs
//              that must appear in the Tick cycle itself
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic En,
  output logic Tick,
  output logic TickNext
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (!Reset || !En || Tick) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

  assign Tick     = En && (cnt == LAST);
  assign TickNext = En && ((CLKS_PER_BIT == 1) || (cnt == PRE));
endmodule

// File: rtl/serial_tx_16.sv
// Parallel-to-serial frame transmitter: start(0), D0..D15 LSB first,
// optional parity, stop(1); every bit held CLKS_PER_BIT cycles.
//   Clk     : system clock
//   Reset   : synchronous, active-low
//   Load    : transmit request, accepted on an edge where Ready=1
//   Data_In : word sampled on the accepting edge
//   Ready   : idle / can accept; also high during the final stop cycle so a
//             held Load starts the next frame with no gap on Tx
//   Busy    : ~Ready
//   Tx      : serial line, idles high
//   Done    : one-cycle pulse in the final stop cycle
module serial_tx_16
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Load,
  input  logic [DATA_BITS-1:0] Data_In,
  output logic                 Ready,
  output logic                 Busy,
  output logic                 Tx,
  output logic                 Done
);
  // With one-cycle bits the stop bit is entirely its own last cycle, so
  // Done/Ready must rise on the edge that enters STOP.
  localparam logic STOP_IS_LAST = (CLKS_PER_BIT == 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] sr;
  logic [3:0]           bitcnt;
  logic                 par;
  logic                 tick, tick_next;
  logic                 accept;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (state != IDLE),
    .Tick     (tick),
    .TickNext (tick_next)
  );

  // Ready is only high in IDLE or in the final stop cycle (where tick=1).
  assign accept = Load && Ready && ((state == IDLE) || tick);
  assign Busy   = ~Ready;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= IDLE;
      sr     <= '0;
      bitcnt <= '0;
      par    <= 1'b0;
      Tx     <= 1'b1;
      Ready  <= 1'b1;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept) begin
        sr     <= Data_In;
        par    <= (^Data_In) ^ (PARITY_ODD != 0);
        bitcnt <= '0;
        state  <= START;
        Tx     <= 1'b0;
        Ready  <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          START: if (tick) begin
            state  <= DATA;
            Tx     <= sr[0];
            sr     <= sr >> 1;
            bitcnt <= '0;
          end
          DATA: if (tick) begin
            if (bitcnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                Tx    <= par;
              end else begin
                state <= STOP;
                Tx    <= 1'b1;
                Done  <= STOP_IS_LAST;
                Ready <= STOP_IS_LAST;
              end
            end else begin
              Tx     <= sr[0];
              sr     <= sr >> 1;
              bitcnt <= bitcnt + 4'd1;
            end
          end
          PARITY: if (tick) begin
            state <= STOP;
            Tx    <= 1'b1;
            Done  <= STOP_IS_LAST;
            Ready <= STOP_IS_LAST;
          end
          STOP: begin
            if (tick) begin
              state <= IDLE;
            end else if (tick_next) begin
              Done  <= 1'b1;
              Ready <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_serial_tx_16.sv
// Bench for serial_tx_16: three configurations share stimulus
// (4/even parity, 4/odd parity, 1/no parity) and are compared each cycle
// against a frame-countdown reference model.
module tb_serial_tx_16;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        Load;
  logic [15:0] Data_In;
  logic [2:0]  tx, rdy, bsy, dn;

  int checks = 0;
  int fails  = 0;

  localparam int CPB  [3] = '{4, 4, 1};
  localparam int PEN  [3] = '{1, 1, 0};
  localparam int PODD [3] = '{0, 1, 0};

  always #5 Clk = ~Clk;

  serial_tx_16 #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Data_In(Data_In),
    .Ready(rdy[0]), .Busy(bsy[0]), .Tx(tx[0]), .Done(dn[0]));
  serial_tx_16 #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Data_In(Data_In),
    .Ready(rdy[1]), .Busy(bsy[1]), .Tx(tx[1]), .Done(dn[1]));
  serial_tx_16 #(.CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u2 (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Data_In(Data_In),
    .Ready(rdy[2]), .Busy(bsy[2]), .Tx(tx[2]), .Done(dn[2]));

  // Reference model: rem = cycles left in the current frame (0 = idle),
  // frm = bit sequence of that frame, index 0 = start bit.
  int          rem [3] = '{0, 0, 0};
  logic [19:0] frm [3];

  function automatic int nlen(int i);
    return (18 + PEN[i]) * CPB[i];
  endfunction

  function automatic logic [19:0] mkframe(logic [15:0] d, int i);
    logic [19:0] f = '1;
    f[0] = 1'b0;
    for (int j = 0; j < 16; j++) f[1+j] = d[j];
    if (PEN[i] != 0) f[17] = (^d) ^ PODD[i][0];
    f[17+PEN[i]] = 1'b1;
    return f;
  endfunction

  always @(posedge Clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!Reset) rem[i] = 0;
      else if (Load && rem[i] <= 1) begin
        rem[i] = nlen(i);
        frm[i] = mkframe(Data_In, i);
      end else if (rem[i] > 0) rem[i] = rem[i] - 1;
    end
  end

  function automatic logic [11:0] expv();
    logic [2:0] t, r, b, d;
    for (int i = 0; i < 3; i++) begin
      t[i] = (rem[i] == 0) ? 1'b1 : frm[i][(nlen(i) - rem[i]) / CPB[i]];
      r[i] = (rem[i] <= 1);
      b[i] = ~r[i];
      d[i] = (rem[i] == 1);
    end
    return {t, r, b, d};
  endfunction

  function automatic logic [11:0] obsv();
    return {tx, rdy, bsy, dn};
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    Load = 1'b0;
    for (int k = 0; k < 100; k++) cyc();
  endtask

  task automatic test_reset();
    Reset = 1'b0; Load = 1'b0; Data_In = '0;
    cyc(); cyc();
    if (obsv() !== 12'b111_111_000_000) begin
      fails++; $display("FAIL reset_state got %b want %b", obsv(), 12'b111_111_000_000);
    end
    checks++;
    Reset = 1'b1;
    cyc();
    if (obsv() !== 12'b111_111_000_000) begin
      fails++; $display("FAIL reset_release got %b want %b", obsv(), 12'b111_111_000_000);
    end
    checks++;
  endtask

  task automatic test_basic();
    logic [18:0] expb = {1'b1, 1'b0, 16'hA5C3, 1'b0};
    int done_at = 0;
    logic rdy77 = 1'b0;
    Data_In = 16'hA5C3; Load = 1'b1;
    cyc();
    Load = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (obsv() !== expv()) begin
        fails++; $display("FAIL basic c=%0d got %b want %b", c, obsv(), expv());
      end
      checks++;
      if (c <= 76 && (c % 4) == 2) begin
        if (tx[0] !== expb[(c-1)/4]) begin
          fails++; $display("FAIL basic_bit %0d got %b want %b", (c-1)/4, tx[0], expb[(c-1)/4]);
        end
        checks++;
      end
      if (dn[0] && done_at == 0) done_at = c;
      if (c == 77) rdy77 = rdy[0];
      cyc();
    end
    if (done_at !== 76) begin
      fails++; $display("FAIL basic_done_cycle got %0d want 76", done_at);
    end
    checks++;
    if (rdy77 !== 1'b1) begin
      fails++; $display("FAIL basic_ready_after got %b want 1", rdy77);
    end
    checks++;
    drain();
  endtask

  task automatic test_ignore_busy();
    logic [15:0] got = '0;
    int ndone = 0;
    Data_In = 16'h1234; Load = 1'b1;
    cyc();
    Load = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (obsv() !== expv()) begin
        fails++; $display("FAIL ignore c=%0d got %b want %b", c, obsv(), expv());
      end
      checks++;
      if (c >= 5 && c <= 68 && (c % 4) == 2) got[(c-5)/4] = tx[0];
      if (dn[0]) ndone++;
      if (c == 10) begin Load = 1'b1; Data_In = 16'hFFFF; end
      if (c == 11) Load = 1'b0;
      cyc();
    end
    if (got !== 16'h1234) begin
      fails++; $display("FAIL ignore_word got %h want 1234", got);
    end
    checks++;
    if (ndone !== 1) begin
      fails++; $display("FAIL ignore_frames got %0d want 1", ndone);
    end
    checks++;
    drain();
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    logic tx77 = 1'b1, tx142 = 1'b0, idle_seen = 1'b0;
    Data_In = 16'h0001; Load = 1'b1;
    cyc();
    Data_In = 16'h8000;
    for (int c = 1; c <= 170; c++) begin
      if (obsv() !== expv()) begin
        fails++; $display("FAIL b2b c=%0d got %b want %b", c, obsv(), expv());
      end
      checks++;
      if (dn[0]) ndone++;
      if (c == 77) tx77 = tx[0];
      if (c == 142) tx142 = tx[0];
      if (c <= 152 && rdy[0] && !dn[0]) idle_seen = 1'b1;
      if (c == 77) Load = 1'b0;
      cyc();
    end
    if (ndone !== 2) begin
      fails++; $display("FAIL b2b_done_count got %0d want 2", ndone);
    end
    checks++;
    if (tx77 !== 1'b0) begin
      fails++; $display("FAIL b2b_second_start got %b want 0", tx77);
    end
    checks++;
    if (tx142 !== 1'b1) begin
      fails++; $display("FAIL b2b_second_msb got %b want 1", tx142);
    end
    checks++;
    if (idle_seen !== 1'b0) begin
      fails++; $display("FAIL b2b_gap got %b want 0", idle_seen);
    end
    checks++;
    drain();
  endtask

  task automatic test_reset_mid();
    Data_In = 16'hFFFF; Load = 1'b1;
    cyc();
    Load = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (obsv() !== expv()) begin
        fails++; $display("FAIL midrst c=%0d got %b want %b", c, obsv(), expv());
      end
      checks++;
      if (c == 30) Reset = 1'b0;
      cyc();
    end
    Reset = 1'b1;
    if ({tx[0], rdy[0], bsy[0], dn[0]} !== 4'b1100) begin
      fails++; $display("FAIL midrst_after got %b want 1100", {tx[0], rdy[0], bsy[0], dn[0]});
    end
    checks++;
    Data_In = 16'h5A3C; Load = 1'b1;
    cyc();
    Load = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (obsv() !== expv()) begin
        fails++; $display("FAIL midrst_frame c=%0d got %b want %b", c, obsv(), expv());
      end
      checks++;
      cyc();
    end
    drain();
  endtask

  task automatic test_parity_len();
    int done2 = 0;
    Data_In = 16'h0001; Load = 1'b1;
    cyc();
    Load = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (obsv() !== expv()) begin
        fails++; $display("FAIL parity c=%0d got %b want %b", c, obsv(), expv());
      end
      checks++;
      if (c == 70) begin
        if (tx[1:0] !== 2'b01) begin
          fails++; $display("FAIL parity_bits odd/even got %b want 01", tx[1:0]);
        end
        checks++;
      end
      if (dn[2] && done2 == 0) done2 = c;
      cyc();
    end
    if (done2 !== 18) begin
      fails++; $display("FAIL noparity_len got %0d want 18", done2);
    end
    checks++;
    drain();
  endtask

  task automatic test_load_in_reset();
    Reset = 1'b0; Load = 1'b1; Data_In = 16'hBEEF;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      if ({tx, rdy, dn} !== 9'b111_111_000) begin
        fails++; $display("FAIL load_in_reset c=%0d got %b want 111111000", c, {tx, rdy, dn});
      end
      checks++;
    end
    Reset = 1'b1; Load = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      if ({tx, rdy, dn} !== 9'b111_111_000) begin
        fails++; $display("FAIL load_after_reset c=%0d got %b want 111111000", c, {tx, rdy, dn});
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int c = 1; c <= 600; c++) begin
      Load    = ($urandom_range(0, 11) == 0);
      Data_In = 16'($urandom);
      cyc();
      if (obsv() !== expv()) begin
        fails++; $display("FAIL random c=%0d got %b want %b", c, obsv(), expv());
      end
      checks++;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_parity_len();
    test_load_in_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
